// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register
// and saturating stall/flush event counters for debug.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [31:0]      PcReset = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      if_id_instr_q, if_id_instr_d;
    logic [31:0]      if_id_pc4_q, if_id_pc4_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             redirect;
    logic             flush;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = branch_taken | jump;
    // A redirect only squashes the fetched word when both PC and IF/ID actually advance.
    assign flush    = redirect & pc_write & if_id_write;

    // Next-PC selection: stall holds, jump beats branch, otherwise sequential.
    always_comb begin
        pc_d = pc_q;
        if (pc_write) begin
            if (jump) begin
                pc_d = {jump_target[31:2], 2'b00};
            end else if (branch_taken) begin
                pc_d = {branch_target[31:2], 2'b00};
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_comb begin
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        if (if_id_write) begin
            if_id_pc4_d = pc_plus4;
            if (flush) begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end else begin
                if_id_instr_d = imem_rdata;
                if_id_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pc_write && (stall_count_q != CntMax)) begin
            stall_count_d = stall_count_q + CntOne;
        end
        if (flush && (flush_count_q != CntMax)) begin
            flush_count_d = flush_count_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= PcReset;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS-style pipeline. It owns the PC register, next-PC selection and the IF/ID pipeline register.
- It consumes the load-use stall controls (pc_write, if_id_write) produced by the hazard detection logic, and the redirect requests resolved in ID.
- It drives the instruction-memory address and presents the fetched instruction, PC+4 and a valid bit to the ID stage.
- It keeps saturating stall and flush event counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on a flush (sll $0,$0,0).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- pc_write  input  1  1 = PC may update; 0 = hold PC (load-use stall).
- if_id_write  input  1  1 = IF/ID may load; 0 = hold IF/ID contents.
- branch_taken  input  1  taken branch resolved in ID this cycle.
- branch_target  input  32  branch destination.
- jump  input  1  jump resolved in ID this cycle.
- jump_target  input  32  jump destination.
- imem_addr  output  32  instruction-memory address (= current PC).
- imem_rdata  input  32  instruction word; combinational (same-cycle) read.
- pc  output  32  current PC register.
- if_id_instr  output  32  IF/ID instruction.
- if_id_pc4  output  32  IF/ID PC+4.
- if_id_valid  output  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
- stall_count  output  CNT_W  number of cycles with pc_write=0; saturates.
- flush_count  output  CNT_W  number of flushes performed; saturates.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - pc = RESET_PC.
  - if_id_instr = NOP_INSTR, if_id_pc4 = 0, if_id_valid = 0.
  - stall_count = 0, flush_count = 0.
  - On the first rising edge after reset deasserts, the instruction at RESET_PC is captured into IF/ID.
- imem_addr = pc, combinationally; it has no separate register.
- pc_plus4 = pc + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- redirect = branch_taken | jump.
- Next-PC priority, evaluated at each rising edge:
  - pc_write=0: pc holds; any redirect that cycle is ignored. The ID stage re-presents the redirect after the stall.
  - pc_write=1 and jump=1: pc = {jump_target[31:2],2'b00}. jump wins over branch_taken if both are set.
  - pc_write=1 and branch_taken=1 (jump=0): pc = {branch_target[31:2],2'b00}.
  - Otherwise: pc = pc_plus4.
  - Target bits [1:0] are always forced to 0.
- IF/ID register, evaluated at each rising edge:
  - if_id_write=0: all three fields hold, including during a redirect.
  - if_id_write=1 and redirect=1 and pc_write=1 (flush): if_id_instr = NOP_INSTR, if_id_pc4 = pc_plus4, if_id_valid = 0.
  - if_id_write=1, no flush: if_id_instr = imem_rdata, if_id_pc4 = pc_plus4, if_id_valid = 1.
- Combination pc_write=1 with if_id_write=0 is not produced by the hazard logic. If it occurs, the PC advances, IF/ID holds, and no error is flagged.
- Counters:
  - stall_count increments by 1 on each rising edge with pc_write=0.
  - flush_count increments by 1 on each edge where a flush is performed.
  - Both stop at all-ones and never wrap.
- Latency:
  - A redirect asserted in cycle N makes pc = target in cycle N+1 and the target instruction appear in IF/ID in cycle N+2.
  - The bubble occupies IF/ID in cycle N+1, giving a one-slot branch penalty.
- No combinational path from the redirect or stall inputs to any registered output. Only imem_addr is combinational, and it derives from pc only.

Test Plan:
- Reset and sequential fetch: assert reset, release, imem returns addr|32'hA000_0000, no stalls or redirects. Required: pc = 0, 4, 8, 12 on successive cycles; IF/ID shows instr 32'hA000_0000, pc4 = 4, valid = 1 one cycle after each fetch.
- Load-use stall: at pc = 8, drive pc_write=0 and if_id_write=0 for 1 cycle. Required: pc stays 8 and IF/ID holds (instr for addr 4, pc4 = 8) for that cycle, then resumes at 12; stall_count = 1.
- Branch flush: at pc = 16, branch_taken=1, branch_target=32'h0000_0103. Required: next cycle pc = 32'h100 and IF/ID = NOP_INSTR with valid = 0; following cycle IF/ID holds the instr at 32'h100 with pc4 = 32'h104; flush_count = 1.
- Stall beats redirect, jump beats branch:
  - Case 1: pc_write=0, if_id_write=0, jump=1 → pc and IF/ID unchanged, flush_count unchanged.
  - Case 2: next cycle pc_write=1, jump=1, jump_target=32'h200, branch_taken=1, branch_target=32'h300 → pc = 32'h200.
- Wrap and saturation:
  - Set the PC to 32'hFFFF_FFFC via jump, then free-run → pc = 0 next.
  - With CNT_W=4, hold pc_write=0 for 20 cycles → stall_count = 15 and stays 15.
- Async reset mid-stall: assert reset between clock edges while pc_write=0 and flush pending. Required: outputs reach reset values immediately, before the next clock edge; both counters read 0.
